// File: rtl/mrm_fila_jogadas.sv
// mrm_fila_jogadas: move queue, press checker and score keeper for the MRM matrix game
// clock/reset_n : rising-edge clock, asynchronous active-low reset
// iniciar/seed  : start pulse (accepted in OCIOSO/FIM) and LFSR seed
// botoes        : synchronised button levels, one bit per button
// jogada_atual/prox_jogada/nivel_fila : queue head, second entry, fill level
// acertou/errou : one-cycle hit/miss pulses
// pontos/linhas_bloq/fim_jogo/pronto  : score, blocked lines, game over, playing
module mrm_fila_jogadas #(
  parameter int N = 4,
  parameter int DEPTH = 8,
  parameter int P = 6,
  parameter int BLOQ_MAX = 7,
  parameter int STREAK = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    iniciar,
  input  logic [15:0]             seed,
  input  logic [N-1:0]            botoes,
  output logic [N-1:0]            jogada_atual,
  output logic [N-1:0]            prox_jogada,
  output logic [$clog2(DEPTH):0]  nivel_fila,
  output logic                    acertou,
  output logic                    errou,
  output logic [P-1:0]            pontos,
  output logic [2:0]              linhas_bloq,
  output logic                    fim_jogo,
  output logic                    pronto
);
  localparam int AW = $clog2(DEPTH);
  localparam int B = $clog2(N);
  localparam int SW = $clog2(STREAK + 1);
  localparam logic [AW:0] CHEIO = (AW+1)'(DEPTH);
  localparam logic [AW:0] QUASE = (AW+1)'(DEPTH - 1);
  localparam logic [B:0] NB = (B+1)'(N);
  localparam logic [2:0] BMAX = 3'(BLOQ_MAX);
  localparam logic [2:0] BPRE = 3'(BLOQ_MAX - 1);
  localparam logic [SW-1:0] SFIM = SW'(STREAK - 1);
  localparam logic [15:0] SEMENTE = 16'hACE1;
  typedef enum logic [1:0] {OCIOSO, ENCHENDO, JOGANDO, FIM} estado_t;
  estado_t estado;
  logic [15:0] lfsr, lfsr_nx;
  logic [N-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic [N-1:0] botoes_d, mov;
  logic [SW-1:0] streak;
  logic [B-1:0] idx;
  logic aceita, press, pop, hit, push;
  always_comb begin
    lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    // fold out-of-range indices back into 0..N-1 for non-power-of-two N
    idx = ({1'b0, lfsr[B-1:0]} >= NB) ? lfsr[B-1:0] - NB[B-1:0] : lfsr[B-1:0];
    mov = N'(1) << idx;
    jogada_atual = (cnt != '0) ? mem[rd] : '0;
    prox_jogada = (|cnt[AW:1]) ? mem[rd + 1'b1] : '0;
    nivel_fila = cnt;
    fim_jogo = estado == FIM;
    pronto = estado == JOGANDO;
    press = (|botoes) && !(|botoes_d);
    aceita = iniciar && (estado == OCIOSO || estado == FIM);
    pop = (estado == JOGANDO) && press && (cnt != '0);
    hit = pop && (botoes == jogada_atual);
    // the pop frees a slot first, so a full queue still refills on a press
    push = (estado == ENCHENDO || estado == JOGANDO) && (cnt != CHEIO || pop);
  end
  always_ff @(posedge clock)
    if (push) mem[wr] <= mov;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= OCIOSO;
      lfsr <= SEMENTE;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      botoes_d <= '0;
      streak <= '0;
      pontos <= '0;
      linhas_bloq <= '0;
      acertou <= 1'b0;
      errou <= 1'b0;
    end else begin
      botoes_d <= botoes;
      acertou <= hit;
      errou <= pop && !hit;
      lfsr <= aceita ? ((seed == 16'h0000) ? SEMENTE : seed) : lfsr_nx;
      if (aceita) begin
        estado <= ENCHENDO;
        rd <= '0;
        wr <= '0;
        cnt <= '0;
        streak <= '0;
        pontos <= '0;
        linhas_bloq <= '0;
      end else begin
        if (pop) rd <= rd + 1'b1;
        if (push) wr <= wr + 1'b1;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        if (estado == ENCHENDO && cnt == QUASE) estado <= JOGANDO;
        if (hit) begin
          pontos <= (&pontos) ? pontos : pontos + 1'b1;
          streak <= (streak == SFIM) ? '0 : streak + 1'b1;
          if (streak == SFIM && linhas_bloq != 3'd0) linhas_bloq <= linhas_bloq - 1'b1;
        end else if (pop) begin
          streak <= '0;
          if (linhas_bloq != BMAX) linhas_bloq <= linhas_bloq + 1'b1;
          if (linhas_bloq >= BPRE) estado <= FIM;
        end
      end
    end
  end
endmodule

// File: tb/tb_mrm_fila_jogadas.sv
// tb_mrm_fila_jogadas: directed self-checking bench for mrm_fila_jogadas (N=4/DEPTH=8 and N=3/DEPTH=4)
module tb_mrm_fila_jogadas;
  logic clock = 1'b0;
  logic reset_n, iniciar;
  logic [15:0] seed;
  logic [3:0] botoes;
  logic [3:0] jogada_atual, prox_jogada, nivel_fila;
  logic acertou, errou, fim_jogo, pronto;
  logic [5:0] pontos;
  logic [2:0] linhas_bloq;
  logic rst3_n, ini3;
  logic [15:0] seed3;
  logic [2:0] b3, j3, p3, n3, lb3;
  logic a3, e3, f3, pr3;
  logic [5:0] pt3;
  int n_chk = 0, n_pass = 0;
  logic [15:0] m_lfsr;
  logic [3:0] m_q[$];
  logic [3:0] m_bd;
  int m_st, m_lb, m_str;
  always #5 clock = ~clock;
  mrm_fila_jogadas dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .seed(seed), .botoes(botoes),
    .jogada_atual(jogada_atual), .prox_jogada(prox_jogada), .nivel_fila(nivel_fila),
    .acertou(acertou), .errou(errou), .pontos(pontos), .linhas_bloq(linhas_bloq),
    .fim_jogo(fim_jogo), .pronto(pronto)
  );
  mrm_fila_jogadas #(.N(3), .DEPTH(4)) u3 (
    .clock(clock), .reset_n(rst3_n), .iniciar(ini3), .seed(seed3), .botoes(b3),
    .jogada_atual(j3), .prox_jogada(p3), .nivel_fila(n3),
    .acertou(a3), .errou(e3), .pontos(pt3), .linhas_bloq(lb3),
    .fim_jogo(f3), .pronto(pr3)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction
  function automatic logic [3:0] mv4(input logic [15:0] l);
    logic [3:0] one;
    one = 4'b0001;
    return one << l[1:0];
  endfunction
  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_q.delete();
    m_bd = '0;
    m_st = 0;
    m_lb = 0;
    m_str = 0;
  endtask
  task automatic model(input logic ini, input logic [15:0] sd, input logic [3:0] b);
    logic prs;
    int st0;
    prs = (b != 0) && (m_bd == 0);
    m_bd = b;
    st0 = m_st;
    if (ini && (m_st == 0 || m_st == 3)) begin
      m_q.delete();
      m_lfsr = (sd == 0) ? 16'hACE1 : sd;
      m_st = 1;
      m_lb = 0;
      m_str = 0;
    end else begin
      if (st0 == 2 && prs && m_q.size() != 0) begin
        if (b == m_q[0]) begin
          m_str++;
          if (m_str == 4) begin
            m_str = 0;
            if (m_lb > 0) m_lb--;
          end
        end else begin
          m_str = 0;
          m_lb++;
          if (m_lb == 7) m_st = 3;
        end
        void'(m_q.pop_front());
      end
      if ((st0 == 1 || st0 == 2) && m_q.size() < 8) m_q.push_back(mv4(m_lfsr));
      if (st0 == 1 && m_q.size() == 8) m_st = 2;
      m_lfsr = nxt(m_lfsr);
    end
  endtask
  task automatic step(input logic ini, input logic [15:0] sd, input logic [3:0] b);
    iniciar = ini;
    seed = sd;
    botoes = b;
    @(posedge clock);
    model(ini, sd, b);
    #1;
  endtask
  function automatic logic [3:0] errada();
    return (m_q[0] == 4'b0001) ? 4'b0010 : 4'b0001;
  endfunction
  task automatic acerta(input string tag, input int pts, input int lb);
    step(1'b0, 16'h0, m_q[0]);
    check({tag, "_acertou"}, acertou, 1);
    check({tag, "_errou"}, errou, 0);
    check({tag, "_pontos"}, pontos, pts);
    check({tag, "_bloq"}, linhas_bloq, lb);
    step(1'b0, 16'h0, 4'b0000);
  endtask
  task automatic erra(input string tag, input logic [3:0] w, input int lb);
    step(1'b0, 16'h0, w);
    check({tag, "_errou"}, errou, 1);
    check({tag, "_acertou"}, acertou, 0);
    check({tag, "_bloq"}, linhas_bloq, lb);
    step(1'b0, 16'h0, 4'b0000);
  endtask
  initial begin
    reset_n = 1'b0;
    rst3_n = 1'b0;
    iniciar = 1'b0;
    seed = '0;
    botoes = '0;
    ini3 = 1'b0;
    seed3 = '0;
    b3 = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_pronto", pronto, 0);
    check("rst_nivel", nivel_fila, 0);
    check("rst_pontos", pontos, 0);
    check("rst_bloq", linhas_bloq, 0);
    check("rst_fim", fim_jogo, 0);
    check("rst_head", jogada_atual, 0);
    check("rst_prox", prox_jogada, 0);
    check("rst_pulses", {acertou, errou}, 0);
    check("rst3_nivel", n3, 0);
    check("rst3_pronto", pr3, 0);
    reset_n = 1'b1;
    rst3_n = 1'b1;
    step(1'b0, 16'h0, 4'b0000);
    check("idle_pronto", pronto, 0);
    // fill with seed 1: pronto exactly 8 cycles after the start edge
    step(1'b1, 16'h0001, 4'b0000);
    check("fill_n0", nivel_fila, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 16'h0, 4'b0000);
      check($sformatf("fill_n%0d", k), nivel_fila, k);
      check($sformatf("fill_pronto%0d", k), pronto, (k == 8) ? 1 : 0);
    end
    check("fill_head", jogada_atual, 4'b0010);
    check("fill_prox", prox_jogada, 4'b0001);
    check("fill_head_model", jogada_atual, m_q[0]);
    check("fill_prox_model", prox_jogada, m_q[1]);
    step(1'b0, 16'h0, 4'b0000);
    check("ini_ignored_play", {pronto, nivel_fila}, {1'b1, 4'd8});
    // hit held for five cycles: one pulse only
    begin
      logic [3:0] h;
      h = m_q[0];
      step(1'b0, 16'h0, h);
      check("hold_acertou", acertou, 1);
      check("hold_pontos", pontos, 1);
      check("hold_nivel", nivel_fila, 8);
      for (int k = 0; k < 4; k++) begin
        step(1'b0, 16'h0, h);
        check($sformatf("hold_norep%0d", k), {acertou, errou}, 0);
        check($sformatf("hold_pts%0d", k), pontos, 1);
      end
      step(1'b0, 16'h0, 4'b0000);
      check("pop_head", jogada_atual, 4'b0001);
      check("pop_head_model", jogada_atual, m_q[0]);
      check("pop_prox_model", prox_jogada, m_q[1]);
      check("pop_nivel", nivel_fila, 8);
    end
    // miss then streak of 4 unblocks one line, further streaks do not underflow
    erra("miss1", errada(), 1);
    acerta("st1", 2, 1);
    acerta("st2", 3, 1);
    acerta("st3", 4, 1);
    acerta("st4", 5, 0);
    for (int k = 0; k < 4; k++) acerta($sformatf("st%0d", k + 5), 6 + k, 0);
    // multi-bit press is always a miss
    erra("multi", 4'b0011, 1);
    for (int k = 2; k <= 7; k++) begin
      erra($sformatf("miss%0d", k), errada(), k);
      check($sformatf("fim%0d", k), fim_jogo, (k == 7) ? 1 : 0);
    end
    check("fim_pronto", pronto, 0);
    check("fim_pontos", pontos, 9);
    step(1'b0, 16'h0, 4'b0001);
    check("fim_press_pulses", {acertou, errou}, 0);
    check("fim_press_bloq", linhas_bloq, 7);
    step(1'b0, 16'h0, 4'b0000);
    // restart with seed 0 falls back to 16'hACE1
    step(1'b1, 16'h0000, 4'b0000);
    check("restart_fim", fim_jogo, 0);
    check("restart_pontos", pontos, 0);
    check("restart_bloq", linhas_bloq, 0);
    check("restart_nivel", nivel_fila, 0);
    for (int k = 1; k <= 8; k++) step(1'b0, 16'h0, 4'b0000);
    check("refill_pronto", pronto, 1);
    check("refill_head", jogada_atual, 4'b0010);
    check("refill_prox", prox_jogada, 4'b0001);
    // score saturates at 63
    for (int k = 1; k <= 63; k++) acerta($sformatf("sat%0d", k), k, 0);
    step(1'b0, 16'h0, m_q[0]);
    check("sat_acertou", acertou, 1);
    check("sat_pontos", pontos, 63);
    // asynchronous reset kills the in-flight pulse at once
    #2 reset_n = 1'b0;
    #1;
    check("arst_acertou", acertou, 0);
    check("arst_pontos", pontos, 0);
    check("arst_nivel", nivel_fila, 0);
    check("arst_pronto", pronto, 0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    // N=3, DEPTH=4 instance
    ini3 = 1'b1;
    seed3 = 16'h0003;
    step(1'b0, 16'h0, 4'b0000);
    ini3 = 1'b0;
    check("n3_start_nivel", n3, 0);
    step(1'b0, 16'h0, 4'b0000);
    check("n3_one_nivel", n3, 1);
    check("n3_one_head", j3, 3'b001);
    check("n3_one_prox", p3, 3'b000);
    step(1'b0, 16'h0, 4'b0000);
    check("n3_two_prox", p3, 3'b010);
    step(1'b0, 16'h0, 4'b0000);
    check("n3_three_pronto", pr3, 0);
    step(1'b0, 16'h0, 4'b0000);
    check("n3_full_nivel", n3, 4);
    check("n3_full_pronto", pr3, 1);
    check("n3_head_onehot", (j3 == 3'b001) || (j3 == 3'b010) || (j3 == 3'b100), 1);
    // reset mid-fill returns to idle
    rst3_n = 1'b0;
    step(1'b0, 16'h0, 4'b0000);
    rst3_n = 1'b1;
    ini3 = 1'b1;
    step(1'b0, 16'h0, 4'b0000);
    ini3 = 1'b0;
    step(1'b0, 16'h0, 4'b0000);
    step(1'b0, 16'h0, 4'b0000);
    check("n3_midfill_nivel", n3, 2);
    #2 rst3_n = 1'b0;
    #1;
    check("n3_arst_nivel", n3, 0);
    check("n3_arst_outs", {j3, p3, pr3, f3, a3, e3, pt3, lb3}, 0);
    step(1'b0, 16'h0, 4'b0000);
    check("n3_arst_idle", {n3, pr3}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mrm_fila_jogadas.md
# mrm_fila_jogadas

Parametrised move-sequence engine for the MRM matrix game: generates pseudo-random one-hot moves into a FIFO, detects player presses, checks each press against the FIFO head, and keeps score, blocked-line count and game-over state. It replaces the single-entry random-move/RAM/compare/score path with a configurable-depth, N-button queue with lookahead. The `matrix_controller` reads its outputs directly.

## Interface
- `N`, 4: number of buttons, i.e. one-hot move width (2..8).
- `DEPTH`, 8: queue depth (power of 2, ≥2).
- `P`, 6: score width.
- `BLOQ_MAX`, 7: blocked-line count that ends the game (≤7).
- `STREAK`, 4: consecutive hits that unblock one line.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `iniciar` in 1: start/restart pulse.
- `seed` in 16: LFSR seed, loaded on `iniciar`.
- `botoes` in N: raw button levels (already synchronised).
- `jogada_atual` out N: queue head, or 0 when empty.
- `prox_jogada` out N: second entry, or 0 when count<2.
- `nivel_fila` out clog2(DEPTH)+1: entries held.
- `acertou` out 1: one-cycle hit pulse.
- `errou` out 1: one-cycle miss pulse.
- `pontos` out P: score.
- `linhas_bloq` out 3: blocked lines.
- `fim_jogo` out 1: sticky game over.
- `pronto` out 1: high in JOGANDO.

## Operation
- Reset: FSM OCIOSO, queue empty, LFSR=16'hACE1, pontos=0, linhas_bloq=0, streak=0, all outputs 0.
- FSM states:
  - OCIOSO: wait for `iniciar` -> ENCHENDO.
  - ENCHENDO: push one move per cycle; when full -> JOGANDO.
  - JOGANDO: check presses and refill.
  - FIM: `fim_jogo`=1, no pushes, presses ignored; `iniciar` -> ENCHENDO.
- `iniciar` in OCIOSO or FIM clears the queue, pontos, linhas_bloq, streak and `fim_jogo`. It loads the LFSR with `seed`, or with 16'hACE1 if `seed`=0. `iniciar` is ignored in ENCHENDO and JOGANDO.
- LFSR: 16-bit Galois, taps 16,14,13,11 (mask 16'hB400), advances every cycle it is not being loaded.
- Move generation:
  - B = clog2(N); idx = lfsr[B-1:0], minus N if idx≥N.
  - Move = 1<<idx.
- Push condition: ENCHENDO or JOGANDO, and not full. Pushes the current move.
- Press detection:
  - `botoes_d` register holds the previous sample.
  - Press = (botoes≠0) && (botoes_d==0).
  - Held buttons do not repeat.
  - `botoes_d` resets to 0.
- In JOGANDO, on a press with queue non-empty:
  - Hit if botoes==head exactly; a multi-bit press is always a miss.
  - Either result pops the head.
  - Hit: `acertou`=1; pontos+1, saturating at 2^P−1; streak+1. When streak reaches STREAK: streak=0 and linhas_bloq−1 if >0.
  - Miss: `errou`=1; streak=0; linhas_bloq+1, saturating at BLOQ_MAX. On reaching BLOQ_MAX -> FIM.
- A press on an empty queue, or in OCIOSO/ENCHENDO/FIM, is ignored: no pulse, no state change.
- Simultaneous push and pop: both apply, count unchanged. Pop occurs before write, so a full queue can accept a push in the same cycle as a pop.

## Timing
- Press sampled at edge k (botoes≠0, botoes_d=0). At edge k: `acertou`/`errou`, pontos, linhas_bloq, pop and FSM update; the pulse is high for cycle k only.
- `jogada_atual` and `prox_jogada` are combinational from queue storage; the new head is visible the cycle after the pop.
- Fill latency: `iniciar` at edge t -> ENCHENDO; pushes at edges t+1..t+DEPTH; JOGANDO and `pronto` from edge t+DEPTH.
- FIM entry is on the same edge as the final `errou` pulse.
- `reset_n` low mid-game: all state returns to reset values immediately, including an in-flight pulse.

## Test plan
- Reset then `iniciar` with seed=16'h0001: `pronto` rises exactly DEPTH=8 cycles later, `nivel_fila`=8, every entry one-hot in N=4 bits, sequence matches the golden LFSR model.
- Press equal to `jogada_atual`, held for 5 cycles: one `acertou` pulse, pontos 0->1, queue refills back to 8, no repeat while held.
- 7 wrong presses (BLOQ_MAX=7): `errou` ×7, linhas_bloq 1..7, FIM on the 7th, `fim_jogo`=1; further presses produce no pulses; `iniciar` clears everything and refills.
- Errou, then 4 hits with STREAK=4: linhas_bloq 1->0 at the 4th hit. An additional 4 hits leave linhas_bloq at 0 (no underflow).
- Force pontos to 63 (P=6) and hit: pontos stays 63. Press 4'b0011: `errou` even if the head is 4'b0001.
- N=3, DEPTH=4 instance: all moves are in {001,010,100}, full at 4, `prox_jogada`=0 when only one entry is present. `reset_n` asserted mid-fill returns the block to OCIOSO with all outputs 0.
